seq_multiplier_n: RTL and testbench

SEQ_MULTIPLIER_N -- requirements
Module: seq_multiplier_n

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_mult_ctrl.sv | 64 ++++++
 rtl/seq_multiplier_n.sv | 86 ++++++++
 tb/tb_seq_multiplier_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the bit-counter width helper.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Bits needed to hold values 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM of the sequential multiplier: sequences IDLE -> CALC (WIDTH cycles) -> FIX
// and produces the registered busy flag and the one-cycle done pulse.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic   i_CLK,
  input  logic   i_RESET,
  input  logic   start,
  output state_e state,
  output logic   busy,
  output logic   done
);

  localparam int CW = cnt_width(WIDTH);

  state_e        state_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;

  // State, remaining-bit counter, busy and done registers.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= CW'(0);
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_CALC;
            cnt_r   <= CW'(WIDTH);
            busy_r  <= 1'b1;
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CW'(0);
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, one operand bit per cycle; signed operands are
// multiplied as magnitudes and the sign is restored in the final FIX cycle.
module seq_multiplier_n
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic               i_START,
  input  logic               i_SIGNED,
  input  logic [WIDTH-1:0]   i_A,
  input  logic [WIDTH-1:0]   i_B,
  output logic               o_BUSY,
  output logic               o_DONE,
  output logic [2*WIDTH-1:0] o_RESULT
);

  state_e               state_s;
  logic                 mode_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH:0]     shift_s;
  logic [2*WIDTH-1:0]   fix_val_s;
  logic [WIDTH-1:0]     mag_a_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   result_r;

  // Magnitude of v; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return WIDTH'(0) - v;
    end else begin
      return v;
    end
  endfunction

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .start   (i_START),
    .state   (state_s),
    .busy    (o_BUSY),
    .done    (o_DONE)
  );

  // Add-and-shift step and the sign-restored final value.
  always_comb begin
    mode_s  = i_SIGNED & (SIGNED_EN != 0);
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
              (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
    shift_s = {sum_s, acc_r[WIDTH-1:0]} >> 1'b1;
    if (neg_r) begin
      fix_val_s = (2*WIDTH)'(0) - acc_r;
    end else begin
      fix_val_s = acc_r;
    end
  end

  // Operand capture, accumulator iteration and result register.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      mag_a_r  <= WIDTH'(0);
      acc_r    <= (2*WIDTH)'(0);
      neg_r    <= 1'b0;
      result_r <= (2*WIDTH)'(0);
    end else begin
      case (state_s)
        ST_IDLE: begin
          if (i_START) begin
            mag_a_r <= mag(i_A, mode_s);
            acc_r   <= {WIDTH'(0), mag(i_B, mode_s)};
            neg_r   <= mode_s & (i_A[WIDTH-1] ^ i_B[WIDTH-1]);
          end
        end
        ST_CALC: acc_r    <= shift_s[2*WIDTH-1:0];
        ST_FIX:  result_r <= fix_val_s;
        default: acc_r    <= acc_r;
      endcase
    end
  end

  assign o_RESULT = result_r;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Self-checking bench for seq_multiplier_n (WIDTH=4): a signed-enabled instance and an
// unsigned-only instance share stimulus and are compared against an arithmetic model.
module tb_seq_multiplier_n;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a, b;
  logic           busy, done, busy_u, done_u;
  logic [2*W-1:0] res, res_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier_n #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .i_CLK(clk), .i_RESET(rst_n), .i_START(start), .i_SIGNED(sgn),
    .i_A(a), .i_B(b), .o_BUSY(busy), .o_DONE(done), .o_RESULT(res)
  );

  seq_multiplier_n #(.WIDTH(W), .SIGNED_EN(0)) dut_u (
    .i_CLK(clk), .i_RESET(rst_n), .i_START(start), .i_SIGNED(sgn),
    .i_A(a), .i_B(b), .o_BUSY(busy_u), .o_DONE(done_u), .o_RESULT(res_u)
  );

  // Operand value as an integer under the chosen interpretation.
  function automatic int to_int(input logic [W-1:0] v, input bit s);
    if (s && v[W-1]) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    int p;
    p = to_int(x, s) * to_int(y, s);
    return (2*W)'(p);
  endfunction

  // Launch one operation (caller is just after a rising edge); returns edges until done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit s, output int lat);
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit s, input logic [2*W-1:0] req);
    int lat;
    run_op(x, y, s, lat);
    n_checks++;
    if (lat !== W + 2) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, W + 2);
    end
    n_checks++;
    if (res !== req || res !== model(x, y, s)) begin
      n_fail++;
      $display("FAIL %s result: got 0x%02h, required 0x%02h", name, res, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #17;
    n_checks++;
    if ({busy, done, res} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b res=0x%02h, required 0/0/0x00", busy, done, res);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    check_op("u_13x11", 4'd13, 4'd11, 1'b0, 8'h8F);
    check_op("u_15x15", 4'd15, 4'd15, 1'b0, 8'hE1);
  endtask

  task automatic test_signed();
    check_op("s_m3x5",  4'hD, 4'h5, 1'b1, 8'hF1);
    check_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
    check_op("s_m8x7",  4'h8, 4'h7, 1'b1, 8'hC8);
  endtask

  task automatic test_zero();
    check_op("s_0xm7", 4'h0, 4'h9, 1'b1, 8'h00);
  endtask

  task automatic test_unsigned_build();
    int lat;
    run_op(4'hD, 4'h5, 1'b1, lat);
    n_checks++;
    if (res_u !== 8'h41) begin
      n_fail++;
      $display("FAIL unsigned_build: got 0x%02h, required 0x41", res_u);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'd7, 4'd6, 1'b0, lat);
    // still inside the done cycle: the next start must be accepted at once
    check_op("b2b_second", 4'hA, 4'h3, 1'b1, model(4'hA, 4'h3, 1'b1));
  endtask

  task automatic test_busy_guard();
    int lat, ndone;
    a = 4'd9; b = 4'd5; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'd3; b = 4'd2; sgn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (res !== 8'd45) begin
      n_fail++;
      $display("FAIL busy_guard_result: got 0x%02h, required 0x%02h", res, 8'd45);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL busy_guard_done_count: got %0d, required 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    a = 4'd11; b = 4'd13; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, res} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_immediate: got busy=%b done=%b res=0x%02h, required 0/0/0x00", busy, done, res);
    end
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || res !== 8'h00) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d bad cycles, required 0", ndone);
    end
    rst_n = 1'b1;
    check_op("after_reset", 4'hC, 4'h3, 1'b1, 8'hF4);
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] x, y;
    bit s;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      run_op(x, y, s, lat);
      // scramble operands after capture; the results must not move
      a = W'($urandom); b = W'($urandom);
      n_checks++;
      if (res !== model(x, y, s) || lat !== W + 2) begin
        n_fail++;
        $display("FAIL random_%0d: %0h*%0h s=%0b got 0x%02h lat %0d, required 0x%02h lat %0d",
                 i, x, y, s, res, lat, model(x, y, s), W + 2);
      end
      n_checks++;
      if (res_u !== model(x, y, 1'b0)) begin
        n_fail++;
        $display("FAIL random_u_%0d: got 0x%02h, required 0x%02h", i, res_u, model(x, y, 1'b0));
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_unsigned_build();
    test_back_to_back();
    test_busy_guard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
